// File: rtl/posit_defines.sv
// Shared definitions for the posit normalize/encode pipeline.
// Holds the default posit geometry, constant functions for the special
// encodings (maxpos, minpos, NaR) and the per-stage flag payload.
package posit_defines;

   localparam int NBITS_DEF = 32;
   localparam int ES_DEF    = 2;
   localparam int MAX_W     = 64;

   // Flags that travel unchanged through every stage.
   typedef struct packed {
      logic sgn;
      logic inf;
      logic zero;
   } stage_flags_t;

   // Largest positive posit: 0 followed by all ones.
   function automatic logic [MAX_W-1:0] maxpos_word(input int nbits);
      maxpos_word = (MAX_W'(1) << (nbits - 1)) - MAX_W'(1);
   endfunction

   // Smallest positive posit: a single one in the lsb.
   function automatic logic [MAX_W-1:0] minpos_word(input int nbits);
      minpos_word = (nbits > 1) ? MAX_W'(1) : MAX_W'(0);
   endfunction

   // Not-a-Real: 1 followed by all zeros.
   function automatic logic [MAX_W-1:0] nar_word(input int nbits);
      nar_word = MAX_W'(1) << (nbits - 1);
   endfunction

endpackage

// File: rtl/shift_right.sv
// Logical right barrel shifter with a selectable fill bit.
// Ports:
//   data_in  - word to shift
//   shamt    - shift distance
//   fill     - bit shifted in at the top
//   data_out - shifted word
//   sticky   - OR of every bit shifted out of the bottom
module shift_right #(
   parameter int N       = 64,
   parameter int SHAMT_W = $clog2(N)
) (
   input  logic [N-1:0]       data_in,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               fill,
   output logic [N-1:0]       data_out,
   output logic               sticky
);

   logic [N-1:0] mask;

   always_comb begin
      data_out = N'({{N{fill}}, data_in} >> shamt);
      mask     = (N'(1) << shamt) - N'(1);
      sticky   = |(data_in & mask);
   end

endmodule

// File: rtl/posit_normalize_pipe.sv
// Three-stage posit normalize/round/encode pipeline.
//   S1: scale clamp, regime/exponent decode, pre-shift word assembly
//   S2: regime barrel shift, guard and sticky collection
//   S3: round-to-nearest-even, saturate, negate, special-case encode
// All stages advance together on en = ~s3_valid | out_ready, so a stalled
// output holds the whole pipe and bubbles are kept in place.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid / in_ready   - input handshake (in_ready == en)
//   in_sgn, in_scale      - sign and two's-complement scale
//   in_fraction           - fraction, msb is the hidden bit
//   in_inf, in_zero       - NaR / zero flags
//   in_truncated          - sticky from upstream arithmetic
//   out_valid / out_ready - output handshake
//   out_result            - encoded posit
//   out_inf, out_zero     - result flags
//   out_inexact           - only with POSIT_NORM_INEXACT_EN: result was rounded
//                           or the scale was clamped
module posit_normalize_pipe
   import posit_defines::*;
#(
   parameter int NBITS   = NBITS_DEF,
   parameter int ES      = ES_DEF,
   parameter int SCALE_W = 9,
   parameter int FRAC_W  = 60
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_sgn,
   input  logic signed [SCALE_W-1:0] in_scale,
   input  logic [FRAC_W-1:0]         in_fraction,
   input  logic                      in_inf,
   input  logic                      in_zero,
   input  logic                      in_truncated,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NBITS-1:0]          out_result,
   output logic                      out_inf,
   output logic                      out_zero
`ifdef POSIT_NORM_INEXACT_EN
   ,
   output logic                      out_inexact
`endif
);

   localparam int WORD_W  = 2 * NBITS;
   localparam int SHAMT_W = $clog2(WORD_W);
   // regime start pair + exponent + fraction without hidden bit
   localparam int FULL_W  = 2 + ES + FRAC_W - 1;

   localparam logic signed [SCALE_W-1:0] SCALE_HI = SCALE_W'((NBITS - 2) << ES);
   localparam logic signed [SCALE_W-1:0] SCALE_LO = SCALE_W'(-((NBITS - 2) << ES));

   localparam logic [NBITS-2:0] MAG_MAX = (NBITS-1)'(maxpos_word(NBITS));
   localparam logic [NBITS-2:0] MAG_MIN = (NBITS-1)'(minpos_word(NBITS));
   localparam logic [NBITS-1:0] NAR     = NBITS'(nar_word(NBITS));

   logic en;
   assign en       = ~out_valid | out_ready;
   assign in_ready = en;

   // The hidden bit is implied by the regime terminator and never encoded.
   logic unused_hidden;
   assign unused_hidden = in_fraction[FRAC_W-1];

   // ---------------- S1: clamp and decode ----------------
   logic signed [SCALE_W-1:0] scale_c;
   logic signed [SCALE_W-1:0] k1;
   logic [SCALE_W-1:0]        k_mag1;
   logic                      k_neg1;
   logic [FULL_W+WORD_W-1:0]  ext1;
   logic [WORD_W-1:0]         word1;
   logic                      lost1;

   always_comb begin
      scale_c = in_scale;
      if (in_scale > SCALE_HI)      scale_c = SCALE_HI;
      else if (in_scale < SCALE_LO) scale_c = SCALE_LO;
      k1     = scale_c >>> ES;
      k_neg1 = k1[SCALE_W-1];
      // Start the word with "10" (k>=0) or "01" (k<0) and shift right by k
      // or -k-1 with the run bit as fill; this yields the full regime run
      // plus its terminator without a separate run-length encoder.
      k_mag1 = k_neg1 ? ~k1 : k1;
      ext1   = {(k_neg1 ? 2'b01 : 2'b10), scale_c[ES-1:0],
                in_fraction[FRAC_W-2:0], {WORD_W{1'b0}}};
      word1  = ext1[FULL_W+WORD_W-1 -: WORD_W];
      lost1  = |ext1[FULL_W-1:0];
   end

   logic               s1_valid;
   stage_flags_t       s1_flags;
   logic [WORD_W-1:0]  s1_word;
   logic [SHAMT_W-1:0] s1_shamt;
   logic               s1_fill;
   logic               s1_sticky;

   // ---------------- S2: regime shift ----------------
   logic [WORD_W-1:0] shifted2;
   logic              shift_sticky2;

   shift_right #(.N(WORD_W)) u_shift (
      .data_in  (s1_word),
      .shamt    (s1_shamt),
      .fill     (s1_fill),
      .data_out (shifted2),
      .sticky   (shift_sticky2)
   );

   logic               s2_valid;
   stage_flags_t       s2_flags;
   logic [NBITS-2:0]   s2_mag;
   logic               s2_guard;
   logic               s2_sticky;

   // ---------------- S3: round and encode ----------------
   logic             inc3;
   logic [NBITS-1:0] sum3;
   logic [NBITS-2:0] mag3;
   logic [NBITS-1:0] res3;

   always_comb begin
      inc3 = s2_guard & (s2_sticky | s2_mag[0]);
      sum3 = {1'b0, s2_mag} + {{(NBITS-1){1'b0}}, inc3};
      mag3 = sum3[NBITS-1] ? MAG_MAX : sum3[NBITS-2:0];
      if (mag3 == '0) mag3 = MAG_MIN;
      res3 = {1'b0, mag3};
      if (s2_flags.sgn) res3 = ~res3 + NBITS'(1);
      if (s2_flags.inf)       res3 = NAR;
      else if (s2_flags.zero) res3 = '0;
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_inf    <= 1'b0;
         out_zero   <= 1'b0;
      end else if (en) begin
         s1_valid   <= in_valid;
         s2_valid   <= s1_valid;
         out_valid  <= s2_valid;
         out_result <= res3;
         out_inf    <= s2_flags.inf;
         out_zero   <= s2_flags.zero & ~s2_flags.inf;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         s1_flags  <= '{sgn: in_sgn, inf: in_inf, zero: in_zero};
         s1_word   <= word1;
         s1_shamt  <= SHAMT_W'(k_mag1);
         s1_fill   <= ~k_neg1;
         s1_sticky <= lost1 | in_truncated;
         s2_flags  <= s1_flags;
         s2_mag    <= shifted2[WORD_W-1 -: NBITS-1];
         s2_guard  <= shifted2[WORD_W-NBITS];
         s2_sticky <= (|shifted2[WORD_W-NBITS-1:0]) | shift_sticky2 | s1_sticky;
      end
   end

`ifdef POSIT_NORM_INEXACT_EN
   logic clamp1;
   logic s1_clamp;
   logic s2_clamp;

   assign clamp1 = (in_scale > SCALE_HI) | (in_scale < SCALE_LO);

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_clamp    <= 1'b0;
         s2_clamp    <= 1'b0;
         out_inexact <= 1'b0;
      end else if (en) begin
         s1_clamp    <= clamp1;
         s2_clamp    <= s1_clamp;
         // Special values are exact by definition.
         out_inexact <= (s2_guard | s2_sticky | s2_clamp) & ~s2_flags.inf & ~s2_flags.zero;
      end
   end
`endif

endmodule
